// File: rtl/hub75_frame_capture.sv
// ---------------------------------------------------------------------------
// hub75_frame_capture
//
// Panel-side receiver for a HUB75 link. Every HUB75 pin is oversampled on
// MCLK through a synchronizer chain. Shift-clock edges push pixel bits into
// two row shift registers (top and bottom half). Latch edges commit both
// rows into a 32 x 64 x 3-bit frame store, which a registered pixel port
// reads back. Protocol errors are flagged as they are seen.
//
// Optional feature: define HUB75_OE_CHECK_EN to add the oe_err output. With
// it defined, a latch that arrives while the panel is enabled (OE low) is
// flagged and is not committed.
//
// Ports
//   MCLK                 master clock, rising edge
//   reset                synchronous, active-low
//   R1/G1/B1, R2/G2/B2   top / bottom half pixel data
//   A, B, C, D           row select, A = LSB
//   LATCH                row latch, rising-edge active
//   CLK_IN               shift clock, rising-edge active
//   OE                   output enable, active-low
//   rd_x, rd_y           pixel read address
//   rd_rgb               {R,G,B} at (rd_x, rd_y), one cycle after the address
//   frame_done           one-cycle pulse after the last top-half row commits
//   frame_count          completed frames, wraps
//   len_err              sticky: a latch saw an edge count other than COLS
//   last_len             edge count at the most recent commit, saturating
//   oe_err               (HUB75_OE_CHECK_EN only) sticky: latch while enabled
// ---------------------------------------------------------------------------
module hub75_frame_capture #(
    parameter int COLS        = 64,
    parameter int ROWS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      MCLK,
    input  logic                      reset,
    input  logic                      R1,
    input  logic                      G1,
    input  logic                      B1,
    input  logic                      R2,
    input  logic                      G2,
    input  logic                      B2,
    input  logic                      A,
    input  logic                      B,
    input  logic                      C,
    input  logic                      D,
    input  logic                      LATCH,
    input  logic                      CLK_IN,
    input  logic                      OE,
    input  logic [$clog2(COLS)-1:0]   rd_x,
    input  logic [$clog2(ROWS)-1:0]   rd_y,
    output logic [2:0]                rd_rgb,
    output logic                      frame_done,
    output logic [7:0]                frame_count,
    output logic                      len_err,
    output logic [7:0]                last_len
`ifdef HUB75_OE_CHECK_EN
    ,
    output logic                      oe_err
`endif
);

    localparam int NSIG = 13;
    localparam int YW   = $clog2(ROWS);
    localparam int HALF = ROWS / 2;
    localparam int ARM  = SYNC_STAGES + 1;
    localparam int FW   = $clog2(SYNC_STAGES + 2);
    localparam logic [7:0] COLS_CNT = 8'(COLS);
    localparam logic [3:0] LAST_ROW = 4'(HALF - 1);

    typedef logic [COLS-1:0][2:0] row_t;

    // ---------------- synchronizer ----------------
    logic [NSIG-1:0] sync_q [SYNC_STAGES];
    logic [NSIG-1:0] s;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value, forming a real pipeline.
    always_ff @(posedge MCLK) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {R1, G1, B1, R2, G2, B2, D, C, B, A, LATCH, CLK_IN, OE};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    logic [2:0] s_top, s_bot;
    logic [3:0] s_row;
    logic       s_latch, s_clk, s_oe;

    assign s_top   = s[12:10];
    assign s_bot   = s[9:7];
    assign s_row   = s[6:3];
    assign s_latch = s[2];
    assign s_clk   = s[1];
    assign s_oe    = s[0];

    // ---------------- edge detection ----------------
    // After reset the chain and history hold zeros, not real samples. Edges
    // are ignored until the history flop holds a genuine pin sample, so a
    // LATCH (or CLK_IN) already high at reset release is not seen as a rise.
    logic          prev_clk, prev_latch;
    logic [FW-1:0] fill;
    logic          armed, clk_rise, latch_rise;

    assign armed = (fill == FW'(ARM));

    always_ff @(posedge MCLK) begin
        if (!reset) begin
            prev_clk   <= 1'b0;
            prev_latch <= 1'b0;
            fill       <= '0;
        end else begin
            prev_clk   <= s_clk;
            prev_latch <= s_latch;
            if (!armed) fill <= fill + FW'(1);
        end
    end

    assign clk_rise   = armed & s_clk & ~prev_clk;
    assign latch_rise = armed & s_latch & ~prev_latch;

    // ---------------- shift / count / commit ----------------
    row_t         top_sr, bot_sr, top_next, bot_next;
    logic [7:0]   edge_cnt, cnt_next;
    logic         commit;
    logic [YW-1:0] top_addr, bot_addr;

    // Post-shift view: a latch in the same cycle as a clock edge commits
    // the row including the bit just shifted in, and counts that edge.
    // NOTE: every signal gets a default first so always_comb never infers
    // a latch when the shift branch is not taken.
    always_comb begin
        top_next = top_sr;
        bot_next = bot_sr;
        cnt_next = edge_cnt;
        if (clk_rise) begin
            top_next = {s_top, top_sr[COLS-1:1]};
            bot_next = {s_bot, bot_sr[COLS-1:1]};
            cnt_next = (edge_cnt == 8'hFF) ? edge_cnt : edge_cnt + 8'd1;
        end
    end

`ifdef HUB75_OE_CHECK_EN
    assign commit = latch_rise & s_oe;
`else
    logic unused_oe;
    assign unused_oe = s_oe;
    assign commit    = latch_rise;
`endif

    assign top_addr = YW'(s_row);
    assign bot_addr = YW'(s_row) + YW'(HALF);

    always_ff @(posedge MCLK) begin
        if (!reset) begin
            top_sr      <= '0;
            bot_sr      <= '0;
            edge_cnt    <= '0;
            last_len    <= '0;
            len_err     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
`ifdef HUB75_OE_CHECK_EN
            oe_err      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            top_sr     <= top_next;
            bot_sr     <= bot_next;
            // Any latch edge restarts the count, committed or suppressed.
            edge_cnt   <= latch_rise ? 8'd0 : cnt_next;
            if (commit) begin
                last_len <= cnt_next;
                if (cnt_next != COLS_CNT) len_err <= 1'b1;
                if (s_row == LAST_ROW) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                end
            end
`ifdef HUB75_OE_CHECK_EN
            if (latch_rise && !s_oe) oe_err <= 1'b1;
`endif
        end
    end

    // ---------------- frame store ----------------
    row_t frame_mem [ROWS];

    // NOTE: the frame store is a RAM and is deliberately left out of reset;
    // only the write is gated so a reset cycle never commits a row.
    always_ff @(posedge MCLK) begin
        if (reset && commit) begin
            frame_mem[top_addr] <= top_next;
            frame_mem[bot_addr] <= bot_next;
        end
    end

    // Registered read; a same-cycle commit to this row is seen next cycle.
    always_ff @(posedge MCLK) begin
        if (!reset) rd_rgb <= '0;
        else        rd_rgb <= frame_mem[rd_y][rd_x];
    end

endmodule

// File: tb/tb_hub75_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_hub75_frame_capture
//
// Directed bench for hub75_frame_capture. A pin-level model predicts every
// output from the bits sent since reset (a queue of pixels per half) and
// the pin history delayed by the synchronizer depth. One process compares
// all outputs every cycle. Literal spot checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_hub75_frame_capture;

    localparam int COLS = 64;
    localparam int ROWS = 32;
    localparam int SS   = 2;

    logic MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic       reset;
    logic       R1, G1, B1, R2, G2, B2, A, B, C, D, LATCH, CLK_IN, OE;
    logic [5:0] rd_x;
    logic [4:0] rd_y;
    logic [2:0] rd_rgb;
    logic       frame_done, len_err;
    logic [7:0] frame_count, last_len;
`ifdef HUB75_OE_CHECK_EN
    logic       oe_err;
`endif

    hub75_frame_capture #(.COLS(COLS), .ROWS(ROWS), .SYNC_STAGES(SS)) dut (
        .MCLK(MCLK), .reset(reset),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .A(A), .B(B), .C(C), .D(D),
        .LATCH(LATCH), .CLK_IN(CLK_IN), .OE(OE),
        .rd_x(rd_x), .rd_y(rd_y), .rd_rgb(rd_rgb),
        .frame_done(frame_done), .frame_count(frame_count),
        .len_err(len_err), .last_len(last_len)
`ifdef HUB75_OE_CHECK_EN
        , .oe_err(oe_err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [2:0] top;
        logic [2:0] bot;
        logic [3:0] row;
        logic       latch;
        logic       clk;
        logic       oe;
    } pins_t;

    pins_t      hist[$];
    logic [2:0] tq[$];
    logic [2:0] bq[$];
    logic [2:0] m_mem [ROWS][COLS];
    bit         m_valid [ROWS];
    int         cyc = 0;
    int         last_rst = 0;
    bit         live = 0;
    logic [7:0] m_cnt, m_last, m_count;
    bit         m_len_err, m_done, m_oe_err, m_rd_valid;
    logic [2:0] m_rd;

    always @(posedge MCLK) begin : model
        pins_t cur, prv;
        bit    ok;
        int    idx;
        cyc++;
        cur = {{R1, G1, B1}, {R2, G2, B2}, {D, C, B, A}, LATCH, CLK_IN, OE};
        hist.push_back(cur);
        if (hist.size() > SS + 2) void'(hist.pop_front());
        if (reset !== 1'b1) begin
            live = 1; last_rst = cyc;
            tq.delete(); bq.delete();
            m_cnt = 0; m_last = 0; m_count = 0;
            m_len_err = 0; m_done = 0; m_oe_err = 0;
            m_rd = 0; m_rd_valid = 1;
        end else if (live) begin
            // Read sees memory before this cycle's commit.
            m_rd_valid = m_valid[rd_y];
            m_rd       = m_mem[rd_y][rd_x];
            m_done     = 0;
            // A pin change becomes visible SS cycles later; the previous
            // sample must postdate reset for an edge to count.
            if (hist.size() == SS + 2 && cyc - SS - 1 > last_rst) begin
                prv = hist[0];
                cur = hist[1];
                if (cur.clk && !prv.clk) begin
                    tq.push_back(cur.top);
                    bq.push_back(cur.bot);
                    if (tq.size() > COLS) void'(tq.pop_front());
                    if (bq.size() > COLS) void'(bq.pop_front());
                    if (m_cnt != 8'd255) m_cnt++;
                end
                if (cur.latch && !prv.latch) begin
                    ok = 1;
`ifdef HUB75_OE_CHECK_EN
                    if (!cur.oe) begin ok = 0; m_oe_err = 1; end
`endif
                    if (ok) begin
                        for (int c = 0; c < COLS; c++) begin
                            idx = tq.size() - COLS + c;
                            m_mem[cur.row][c] = 3'b000;
                            m_mem[int'(cur.row) + ROWS/2][c] = 3'b000;
                            if (idx >= 0) begin
                                m_mem[cur.row][c] = tq[idx];
                                m_mem[int'(cur.row) + ROWS/2][c] = bq[idx];
                            end
                        end
                        m_valid[cur.row] = 1;
                        m_valid[int'(cur.row) + ROWS/2] = 1;
                        m_last = m_cnt;
                        if (m_cnt != COLS) m_len_err = 1;
                        if (cur.row == 4'd15) begin m_done = 1; m_count++; end
                    end
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge MCLK) begin
        if (live) begin
            check("frame_done", frame_done, m_done);
            check("frame_count", frame_count, m_count);
            check("len_err", len_err, m_len_err);
            check("last_len", last_len, m_last);
`ifdef HUB75_OE_CHECK_EN
            check("oe_err", oe_err, m_oe_err);
`endif
            if (m_rd_valid) check("rd_rgb", rd_rgb, m_rd);
            if (frame_done === 1'b1) done_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic send_bit(input logic [2:0] top, input logic [2:0] bot);
        {R1, G1, B1} = top;
        {R2, G2, B2} = bot;
        CLK_IN = 1'b0;
        tick(); tick();
        CLK_IN = 1'b1;
        tick(); tick();
    endtask

    task automatic do_latch(input logic [3:0] row, input logic oe);
        {D, C, B, A} = row;
        OE = oe;
        tick();
        LATCH = 1'b1;
        tick(); tick(); tick();
        LATCH = 1'b0;
        tick(); tick(); tick();
        OE = 1'b1;
    endtask

    task automatic read_px(input int x, input int y, input logic [2:0] exp, input string name);
        rd_x = 6'(x);
        rd_y = 5'(y);
        tick();
        check(name, rd_rgb, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {R1, G1, B1, R2, G2, B2, A, B, C, D, CLK_IN} = '0;
        OE = 1'b1; rd_x = '0; rd_y = '0;
        LATCH = 1'b1;               // high across reset release
        tick(); tick(); tick();
        reset = 1'b1;
        repeat (6) tick();
        check("reset_len_err", len_err, 1'b0);
        check("reset_last_len", last_len, 8'd0);
        check("reset_count", frame_count, 8'd0);
        LATCH = 1'b0;
        repeat (4) tick();

        // Full frame: top = col[0], bottom = ~col[0]
        for (int r = 0; r < 16; r++) begin
            for (int x = 0; x < COLS; x++) send_bit({3{x[0]}}, {3{~x[0]}});
            do_latch(4'(r), 1'b1);
        end
        tick(); tick();
        check("frame_done_pulses", done_seen, 1);
        check("frame_count_1", frame_count, 8'd1);
        check("full_len_err", len_err, 1'b0);
        check("full_last_len", last_len, 8'd64);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                rd_x = 6'(x); rd_y = 5'(y);
                tick();
            end
        read_px(0, 0, 3'b000, "px_0_0");
        read_px(1, 0, 3'b111, "px_1_0");
        read_px(0, 16, 3'b111, "px_0_16");
        read_px(1, 31, 3'b000, "px_1_31");

        // Column order: only the first bit carries R
        for (int x = 0; x < COLS; x++) send_bit((x == 0) ? 3'b100 : 3'b000, 3'b000);
        do_latch(4'd3, 1'b1);
        read_px(0, 3, 3'b100, "order_col0");
        read_px(63, 3, 3'b000, "order_col63");

        // CLK_IN and LATCH rise together on the 64th edge; read row 7 meanwhile
        rd_x = 6'd63; rd_y = 5'd7;
        for (int x = 0; x < COLS - 1; x++) send_bit(3'b000, 3'b000);
        {R1, G1, B1} = 3'b101; {R2, G2, B2} = 3'b000;
        {D, C, B, A} = 4'd7; CLK_IN = 1'b0;
        tick(); tick();
        CLK_IN = 1'b1; LATCH = 1'b1;
        tick(); tick(); tick();
        check("same_cycle_old", rd_rgb, 3'b111);
        tick();
        check("same_cycle_new", rd_rgb, 3'b101);
        check("same_cycle_len", last_len, 8'd64);
        CLK_IN = 1'b0; LATCH = 1'b0;
        repeat (3) tick();

        // Short row: 60 edges
        for (int x = 0; x < 60; x++) send_bit(3'b010, 3'b000);
        do_latch(4'd9, 1'b1);
        check("short_last_len", last_len, 8'd60);
        check("short_len_err", len_err, 1'b1);
        read_px(0, 9, 3'b000, "short_col0");
        read_px(3, 9, 3'b101, "short_col3");
        read_px(4, 9, 3'b010, "short_col4");
        read_px(63, 9, 3'b010, "short_col63");

        // Reset mid-row
        for (int x = 0; x < 30; x++) send_bit(3'b001, 3'b111);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        for (int x = 0; x < COLS; x++) send_bit(3'b110, 3'b001);
        do_latch(4'd2, 1'b1);
        check("rst_last_len", last_len, 8'd64);
        check("rst_len_err", len_err, 1'b0);
        read_px(0, 2, 3'b110, "rst_row2");
        read_px(63, 18, 3'b001, "rst_row18");
        read_px(5, 9, 3'b010, "rst_keep_9");
        read_px(1, 0, 3'b111, "rst_keep_0");
        read_px(0, 16, 3'b111, "rst_keep_16");

`ifdef HUB75_OE_CHECK_EN
        for (int x = 0; x < COLS; x++) send_bit(3'b011, 3'b100);
        do_latch(4'd5, 1'b0);
        check("oe_err_set", oe_err, 1'b1);
        read_px(0, 5, 3'b000, "oe_keep_5");
        read_px(0, 21, 3'b111, "oe_keep_21");
        for (int x = 0; x < COLS; x++) send_bit(3'b011, 3'b100);
        do_latch(4'd5, 1'b1);
        check("oe_err_sticky", oe_err, 1'b1);
        read_px(0, 5, 3'b011, "oe_commit_5");
        read_px(63, 21, 3'b100, "oe_commit_21");
`else
        for (int x = 0; x < COLS; x++) send_bit(3'b011, 3'b100);
        do_latch(4'd5, 1'b0);
        read_px(0, 5, 3'b011, "oe_ignored_5");
        read_px(0, 21, 3'b100, "oe_ignored_21");
`endif
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
